// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-RAM program loader.
package loader_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

  // Byte position within a 32-bit instruction word (k = 0..3).
  typedef logic [1:0] lane_t;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  // Extra bits above the word-count width for the run-budget counter.
  localparam int unsigned BUDGET_EXTRA_W = 8;

  // Byte written at address offset `lane` of a word, for either endianness.
  function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                  input lane_t lane,
                                                  input logic big_endian);
    lane_t idx;
    idx = big_endian ? lane_t'(2'd3 - lane) : lane;
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/loader_byte_serializer.sv
// Holds one instruction word and writes it as 4 consecutive byte strobes.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   load                  capture load_word / load_addr; first byte is output next cycle
//   load_word, load_addr  word to emit and byte address of its lane 0
//   we, addr, wdata       registered byte-write port
//   lane                  lane currently on the write port
//   last_c                lane 3 is being written this cycle
module loader_byte_serializer
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [BYTE_W-1:0] wdata,
  output logic [1:0]        lane,
  output logic              last_c
);

  localparam logic BE = (BIG_ENDIAN != 0);

  logic [WORD_W-1:0] word;

  // A new load may overwrite the word during its lane-3 write: no idle gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word  <= '0;
      lane  <= '0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (load) begin
      word  <= load_word;
      lane  <= 2'd0;
      we    <= 1'b1;
      addr  <= load_addr;
      wdata <= lane_byte(load_word, 2'd0, BE);
    end else if (we) begin
      if (lane == 2'd3) begin
        we <= 1'b0;
      end else begin
        lane  <= lane + 2'd1;
        addr  <= addr + ADDR_W'(1);
        wdata <= lane_byte(word, lane + 2'd1, BE);
      end
    end
  end

  assign last_c = we && (lane == 2'd3);

endmodule

// File: rtl/imem_program_loader.sv
// Loads a stream of instruction words byte-serially into instruction RAM while
// holding the core in reset, then releases reset for a cycle budget and flags done.
// Ports:
//   clock, reset     rising-edge clock, async active-high reset
//   start            begin a load/run sequence (accepted only when idle)
//   word_count       words to load, sampled on an accepted start
//   in_valid/ready   instruction word handshake, in_data is the word
//   mem_we/addr/wdata byte write port to instruction RAM
//   core_reset       reset to the core, low only while running
//   busy             sequence in progress
//   done, err        sticky completion / oversize-request flags
//   loaded_words     words completely written so far
module imem_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS      = 256,
  parameter int unsigned ADDR_W           = 10,
  parameter int unsigned CNT_W            = 9,
  parameter int unsigned BIG_ENDIAN       = 1,
  parameter int unsigned BASE_ADDR        = 0,
  parameter int unsigned CYCLES_PER_INSTR = 1,
  parameter int unsigned DRAIN_CYCLES     = 4,
  parameter int unsigned RESET_HOLD       = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  loaded_words
);

  localparam int unsigned BUDGET_W  = CNT_W + BUDGET_EXTRA_W;
  localparam int unsigned HOLD_LAST = (RESET_HOLD > 0) ? RESET_HOLD - 1 : 0;
  localparam int unsigned HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  state_t              state;
  logic [CNT_W-1:0]    target;
  logic [CNT_W-1:0]    issued;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [BUDGET_W-1:0] run_cnt;

  logic                accept_c;
  logic [CNT_W-1:0]    issued_next_c;
  logic                ready_next_c;
  logic [BUDGET_W-1:0] budget_c;
  logic [BUDGET_W-1:0] run_load_c;
  logic [ADDR_W-1:0]   word_addr_c;
  logic [1:0]          sr_lane;
  logic                sr_last_c;

  assign accept_c      = in_valid && in_ready;
  assign issued_next_c = issued + CNT_W'(accept_c);
  assign word_addr_c   = ADDR_W'(BASE_ADDR) + ADDR_W'({issued, 2'b00});

  // in_ready is registered, so predict whether the serializer will be free
  // (idle or on its lane-3 write) in the coming cycle.
  always_comb begin
    ready_next_c = !accept_c && (!mem_we || sr_lane == 2'd3 || sr_lane == 2'd2)
                   && (issued_next_c < target);
    budget_c     = BUDGET_W'(target) * BUDGET_W'(CYCLES_PER_INSTR) + BUDGET_W'(DRAIN_CYCLES);
    run_load_c   = (budget_c == '0) ? '0 : budget_c - BUDGET_W'(1);
  end

  loader_byte_serializer #(
    .ADDR_W     (ADDR_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (accept_c),
    .load_word (in_data),
    .load_addr (word_addr_c),
    .we        (mem_we),
    .addr      (mem_addr),
    .wdata     (mem_wdata),
    .lane      (sr_lane),
    .last_c    (sr_last_c)
  );

  // Sequencer: IDLE -> LOAD -> SETTLE -> RUN -> IDLE, all outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      core_reset   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      in_ready     <= 1'b0;
      loaded_words <= '0;
      target       <= '0;
      issued       <= '0;
      hold_cnt     <= '0;
      run_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            loaded_words <= '0;
            issued       <= '0;
            target       <= word_count;
            if (32'(word_count) > DEPTH_WORDS) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else if (word_count == '0) begin
              state    <= SETTLE;
              busy     <= 1'b1;
              hold_cnt <= HOLD_W'(HOLD_LAST);
            end else begin
              state    <= LOAD;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          issued   <= issued_next_c;
          in_ready <= ready_next_c;
          if (sr_last_c) begin
            loaded_words <= loaded_words + CNT_W'(1);
            if (loaded_words + CNT_W'(1) == target) begin
              state    <= SETTLE;
              in_ready <= 1'b0;
              hold_cnt <= HOLD_W'(HOLD_LAST);
            end
          end
        end

        SETTLE: begin
          if (hold_cnt == '0) begin
            state      <= RUN;
            core_reset <= 1'b0;
            run_cnt    <= run_load_c;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end

        RUN: begin
          if (run_cnt == '0) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            run_cnt <= run_cnt - BUDGET_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
